// File: rtl/ifft4_engine.sv
// 4-point radix-2 inverse FFT: loads X[0..3], two scaled butterfly stages with +j twiddle,
// then drains x[0..3]. One frame in flight; 10-cycle minimum frame period.
module ifft4_engine #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int H = WIDTH / 2;

  typedef enum logic [1:0] {
    LOAD,
    STAGE1,
    STAGE2,
    DRAIN
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       cnt;
  logic [1:0]       ocnt;
  logic [WIDTH-1:0] xin  [4];
  logic [WIDTH-1:0] a    [4];
  logic [WIDTH-1:0] obuf [4];

  function automatic logic [H:0] sext(input logic [H-1:0] v);
    return {v[H-1], v};
  endfunction

  // (p +/- q) >>> 1 per component, computed one bit wider so the sum cannot wrap.
  function automatic logic [WIDTH-1:0] bfly(input logic [WIDTH-1:0] p,
                                            input logic [WIDTH-1:0] q,
                                            input logic             sub);
    logic [H:0] s_re;
    logic [H:0] s_im;
    if (sub) begin
      s_re = sext(p[H-1:0]) - sext(q[H-1:0]);
      s_im = sext(p[WIDTH-1:H]) - sext(q[WIDTH-1:H]);
    end else begin
      s_re = sext(p[H-1:0]) + sext(q[H-1:0]);
      s_im = sext(p[WIDTH-1:H]) + sext(q[WIDTH-1:H]);
    end
    return {s_im[H:1], s_re[H:1]};
  endfunction

  // (j * (p - q)) >>> 1; the rotation negates the wide difference, so it never overflows.
  function automatic logic [WIDTH-1:0] rot_diff(input logic [WIDTH-1:0] p,
                                                input logic [WIDTH-1:0] q);
    logic [H:0] d_re;
    logic [H:0] d_im;
    logic [H:0] n_im;
    d_re = sext(p[H-1:0]) - sext(q[H-1:0]);
    d_im = sext(p[WIDTH-1:H]) - sext(q[WIDTH-1:H]);
    n_im = -d_im;
    return {d_re[H:1], n_im[H:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOAD;
      cnt   <= '0;
      ocnt  <= '0;
    end else begin
      state <= state_nxt;
      if (in_valid && in_ready) cnt <= cnt + 2'd1;
      if (out_valid && out_ready) ocnt <= ocnt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) xin[cnt] <= in_data;
    if (state == STAGE1) begin
      a[0] <= bfly(xin[0], xin[2], 1'b0);
      a[1] <= bfly(xin[0], xin[2], 1'b1);
      a[2] <= bfly(xin[1], xin[3], 1'b0);
      a[3] <= rot_diff(xin[1], xin[3]);
    end
    if (state == STAGE2) begin
      obuf[0] <= bfly(a[0], a[2], 1'b0);
      obuf[1] <= bfly(a[1], a[3], 1'b0);
      obuf[2] <= bfly(a[0], a[2], 1'b1);
      obuf[3] <= bfly(a[1], a[3], 1'b1);
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state)
      LOAD: begin
        in_ready = rst_n;
        if (in_valid && cnt == 2'd3) state_nxt = STAGE1;
      end
      STAGE1: state_nxt = STAGE2;
      STAGE2: state_nxt = DRAIN;
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = obuf[ocnt];
        out_last  = (ocnt == 2'd3);
        if (out_ready && ocnt == 2'd3) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

endmodule

// File: tb/tb_ifft4_engine.sv
// Self-checking bench for ifft4_engine: directed vector table, randomized frames
// against a reference model, backpressure, back-to-back throughput and mid-frame reset.
module tb_ifft4_engine;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  ifft4_engine #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string             name;
    logic [3:0][31:0]  x;
    logic [3:0][31:0]  y;
  } vec_t;

  vec_t tbl[4];

  function automatic logic [31:0] cx(input int re, input int im);
    logic [31:0] r;
    r = {im[15:0], re[15:0]};
    return r;
  endfunction

  // Reference: two scaled radix-2 stages with floor rounding, in plain integer arithmetic.
  function automatic logic [3:0][31:0] ref_ifft(input logic [3:0][31:0] xv);
    int xr[4];
    int xi[4];
    int ar[4];
    int ai[4];
    logic [3:0][31:0] y;
    for (int k = 0; k < 4; k++) begin
      xr[k] = int'($signed(xv[k][15:0]));
      xi[k] = int'($signed(xv[k][31:16]));
    end
    ar[0] = (xr[0] + xr[2]) >>> 1;   ai[0] = (xi[0] + xi[2]) >>> 1;
    ar[1] = (xr[0] - xr[2]) >>> 1;   ai[1] = (xi[0] - xi[2]) >>> 1;
    ar[2] = (xr[1] + xr[3]) >>> 1;   ai[2] = (xi[1] + xi[3]) >>> 1;
    ar[3] = (-(xi[1] - xi[3])) >>> 1; ai[3] = (xr[1] - xr[3]) >>> 1;
    y[0] = cx((ar[0] + ar[2]) >>> 1, (ai[0] + ai[2]) >>> 1);
    y[1] = cx((ar[1] + ar[3]) >>> 1, (ai[1] + ai[3]) >>> 1);
    y[2] = cx((ar[0] - ar[2]) >>> 1, (ai[0] - ai[2]) >>> 1);
    y[3] = cx((ar[1] - ar[3]) >>> 1, (ai[1] - ai[3]) >>> 1);
    return y;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Drives one frame; c returns the cycle of the 4th handshake. gaps inserts idle beats with junk data.
  task automatic send_frame(input logic [3:0][31:0] x, input bit gaps, output int c);
    int i = 0;
    int budget = 0;
    c = -1;
    while (i < 4 && budget < 300) begin
      @(negedge clk);
      budget++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = $urandom;
      end else begin
        in_valid = 1'b1;
        in_data  = x[i];
        if (in_ready) begin
          if (i == 3) c = cyc;
          i++;
        end
      end
    end
    if (i < 4) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got %0d beats expected 4", i);
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: repeating 1-0-0-1 ready pattern.
  task automatic recv_frame(input int mode, input int nbeats,
                            output logic [3:0][31:0] y, output int first);
    int n = 0;
    int budget = 0;
    int k = 0;
    bit hold = 1'b0;
    logic [31:0] pd = '0;
    logic        pl = 1'b0;
    first = -1;
    y = '0;
    while (n < nbeats && budget < 300) begin
      @(negedge clk);
      budget++;
      if (hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", out_data, pd);
        check("hold_last", 32'(out_last), 32'(pl));
      end
      if (out_valid) begin
        if (first < 0) first = cyc;
        case (mode)
          0:       out_ready = 1'b1;
          1:       out_ready = 1'($urandom_range(0, 1));
          default: out_ready = (k % 4 == 0) || (k % 4 == 3);
        endcase
        k++;
        if (out_ready) begin
          y[n] = out_data;
          check("out_last", 32'(out_last), 32'(n == 3));
          n++;
          hold = 1'b0;
        end else begin
          hold = 1'b1;
          pd   = out_data;
          pl   = out_last;
        end
      end else begin
        out_ready = (mode == 0);
        hold      = 1'b0;
      end
    end
    if (n < nbeats) begin
      vectors++;
      miscompares++;
      $display("FAIL recv_timeout: got %0d beats expected %0d", n, nbeats);
    end
  endtask

  logic [3:0][31:0] fx;
  logic [3:0][31:0] fy;
  logic [3:0][31:0] fexp;
  logic [3:0][31:0] bx[3];
  logic [3:0][31:0] by[3];
  int cc[3];
  int ff[3];
  int c0;
  int f0;

  initial begin
    tbl[0].name = "impulse";
    tbl[0].x = {32'h0, 32'h0, 32'h0, cx(8192, 0)};
    tbl[0].y = {cx(2048, 0), cx(2048, 0), cx(2048, 0), cx(2048, 0)};
    tbl[1].name = "dc";
    tbl[1].x = {cx(4096, 0), cx(4096, 0), cx(4096, 0), cx(4096, 0)};
    tbl[1].y = {32'h0, 32'h0, 32'h0, cx(4096, 0)};
    tbl[2].name = "rotation";
    tbl[2].x = {32'h0, 32'h0, cx(8192, 0), 32'h0};
    tbl[2].y = {cx(0, -2048), cx(-2048, 0), cx(0, 2048), cx(2048, 0)};
    tbl[3].name = "width_boundary";
    tbl[3].x = {cx(0, 32767), 32'h0, cx(0, -32768), 32'h0};
    tbl[3].y = {cx(-16384, 0), cx(0, 0), cx(16383, 0), cx(0, -1)};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_last", 32'(out_last), 32'd0);
    check("reset_out_data", out_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", 32'(in_ready), 32'd1);

    for (int t = 0; t < 4; t++) begin
      fork
        send_frame(tbl[t].x, 1'b0, c0);
        recv_frame(0, 4, fy, f0);
      join
      for (int n = 0; n < 4; n++) check({tbl[t].name, "_data"}, fy[n], tbl[t].y[n]);
      check({tbl[t].name, "_latency"}, f0, c0 + 3);
    end

    // Backpressure with the 1-0-0-1 ready pattern and gapped input.
    fx = {cx(-100, 300), cx(7, -9), cx(1234, 55), cx(-5000, 2000)};
    fexp = ref_ifft(fx);
    fork
      send_frame(fx, 1'b1, c0);
      recv_frame(2, 4, fy, f0);
    join
    for (int n = 0; n < 4; n++) check("pattern_bp_data", fy[n], fexp[n]);

    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < 4; k++) fx[k] = $urandom;
      fexp = ref_ifft(fx);
      fork
        send_frame(fx, 1'b1, c0);
        recv_frame(1, 4, fy, f0);
      join
      for (int n = 0; n < 4; n++) check("random_data", fy[n], fexp[n]);
      check("random_latency", f0, c0 + 3);
    end

    for (int f = 0; f < 3; f++) for (int k = 0; k < 4; k++) bx[f][k] = $urandom;
    fork
      begin
        for (int f = 0; f < 3; f++) send_frame(bx[f], 1'b0, cc[f]);
      end
      begin
        for (int f = 0; f < 3; f++) recv_frame(0, 4, by[f], ff[f]);
      end
    join
    for (int f = 0; f < 3; f++) begin
      fexp = ref_ifft(bx[f]);
      for (int n = 0; n < 4; n++) check("b2b_data", by[f][n], fexp[n]);
    end
    check("b2b_in_period_1", cc[1] - cc[0], 10);
    check("b2b_in_period_2", cc[2] - cc[1], 10);
    check("b2b_out_period", ff[2] - ff[1], 10);

    // Reset after two input beats: partial frame must be discarded.
    @(negedge clk); in_valid = 1'b1; in_data = cx(30000, 30000);
    @(negedge clk); in_data = cx(-30000, 12345);
    @(negedge clk); in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("midload_reset_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    fx = {cx(-3, 4), cx(100, 200), cx(-8000, 16000), cx(512, -512)};
    fexp = ref_ifft(fx);
    fork
      send_frame(fx, 1'b0, c0);
      recv_frame(0, 4, fy, f0);
    join
    for (int n = 0; n < 4; n++) check("after_load_reset_data", fy[n], fexp[n]);

    // Reset in DRAIN after x1 has left.
    for (int k = 0; k < 4; k++) fx[k] = $urandom;
    fexp = ref_ifft(fx);
    fork
      send_frame(fx, 1'b0, c0);
      recv_frame(0, 2, fy, f0);
    join
    check("pre_reset_x0", fy[0], fexp[0]);
    check("pre_reset_x1", fy[1], fexp[1]);
    @(negedge clk); rst_n = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("drain_reset_out_valid", 32'(out_valid), 32'd0);
    check("drain_reset_out_last", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) fx[k] = $urandom;
    fexp = ref_ifft(fx);
    fork
      send_frame(fx, 1'b1, c0);
      recv_frame(0, 4, fy, f0);
    join
    for (int n = 0; n < 4; n++) check("after_drain_reset_data", fy[n], fexp[n]);
    check("after_drain_reset_latency", f0, c0 + 3);

    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
